// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam int unsigned FETCH_BLOCK_BYTES = 8;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        valid;
  } fetch_slot_t;

  typedef struct packed {
    logic [31:0] block_addr;
    logic        odd;
  } fetch_tag_t;

  function automatic logic [31:0] block_base(input logic [31:0] a);
    return {a[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_tag_fifo.sv
// Per-request tag queue: remembers block address and entry half for each
// accepted fetch so in-order responses can be unpacked correctly.
module fetch_tag_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  fetch_tag_t push_tag,
  output fetch_tag_t head_tag
);

  localparam logic [1:0] LAST    = 2'(DEPTH - 1);
  localparam logic [1:0] DEPTH_L = 2'(DEPTH);

  // Storage is sized for the widest pointer; only DEPTH entries are used.
  fetch_tag_t  entries [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [1:0]  count;
  logic        do_push;
  logic        do_pop;

  assign do_pop   = pop & (count != 2'd0);
  assign do_push  = push & ((count != DEPTH_L) | do_pop);
  assign head_tag = entries[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: issues aligned 64-bit fetches, unpacks in-order responses
// into two buffer slots, and flushes/drains on redirect.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic [31:0] instructionA,
  output logic [31:0] instructionB,
  output logic [31:0] addressA,
  output logic [31:0] addressB,
  output logic        instructionA_valid,
  output logic        instructionB_valid,
  output logic        flush
);

  localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [1:0]   outstanding;
  logic [1:0]   discard, discard_next;
  logic         accept;
  logic         resp;
  logic         keep;
  fetch_tag_t   head_tag;
  fetch_slot_t  slot_a, slot_b;
  fetch_slot_t  slot_a_next, slot_b_next;

  // rst gates the request so nothing is offered while reset is held.
  assign mem_req  = rst & (state == RUN) & ~stall & ~redirect & (outstanding < MAX_OUT);
  assign mem_addr = block_base(pc);
  assign accept   = mem_req & mem_ready;
  assign resp     = mem_rvalid & (outstanding != 2'd0);

  fetch_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .pop      (resp),
    .push_tag ('{block_addr: block_base(pc), odd: pc[2]}),
    .head_tag (head_tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // A response in the redirect cycle is dropped, so it no longer counts
  // toward the number of stale responses still to be discarded.
  always_comb begin
    state_next   = state;
    discard_next = discard;
    keep         = 1'b0;
    if (redirect) begin
      discard_next = outstanding - {1'b0, resp};
      state_next   = (discard_next != 2'd0) ? DRAIN : RUN;
    end else begin
      case (state)
        RUN:   keep = resp;
        DRAIN: begin
          if (resp) begin
            discard_next = discard - 2'd1;
            if (discard_next == 2'd0) state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    slot_b_next = '{instr: slot_b.instr, addr: slot_b.addr, valid: 1'b0};
    if (head_tag.odd) begin
      slot_a_next = '{instr: mem_rdata[63:32], addr: head_tag.block_addr + 32'd4, valid: 1'b1};
    end else begin
      slot_a_next = '{instr: mem_rdata[31:0], addr: head_tag.block_addr, valid: 1'b1};
      slot_b_next = '{instr: mem_rdata[63:32], addr: head_tag.block_addr + 32'd4, valid: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      discard     <= 2'd0;
      flush       <= 1'b0;
      slot_a      <= '0;
      slot_b      <= '0;
    end else begin
      outstanding <= outstanding + {1'b0, accept} - {1'b0, resp};
      discard     <= discard_next;
      flush       <= redirect;
      if (redirect) begin
        pc <= redirect_pc & ~32'h3;
      end else if (accept) begin
        pc <= block_base(pc) + 32'(FETCH_BLOCK_BYTES);
      end
      if (keep) begin
        slot_a <= slot_a_next;
        slot_b <= slot_b_next;
      end else begin
        slot_a.valid <= 1'b0;
        slot_b.valid <= 1'b0;
      end
    end
  end

  assign instructionA       = slot_a.instr;
  assign addressA           = slot_a.addr;
  assign instructionA_valid = slot_a.valid;
  assign instructionB       = slot_b.instr;
  assign addressB           = slot_b.addr;
  assign instructionB_valid = slot_b.valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'h0;
  logic [31:0] instructionA, instructionB, addressA, addressB;
  logic        instructionA_valid, instructionB_valid, flush;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct packed {
    logic        red;
    logic [31:0] rpc;
    logic        st;
    logic        rdy;
    logic        rv;
    logic [63:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        fl;
    logic        va;
    logic [31:0] ia;
    logic [31:0] aa;
    logic        vb;
    logic [31:0] ib;
    logic [31:0] ab;
  } vec_t;

  vec_t vecs [32];

  fetch_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc),
    .stall              (stall),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_ready          (mem_ready),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .instructionA       (instructionA),
    .instructionB       (instructionB),
    .addressA           (addressA),
    .addressB           (addressB),
    .instructionA_valid (instructionA_valid),
    .instructionB_valid (instructionB_valid),
    .flush              (flush)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic red, input logic [31:0] rpc, input logic st, input logic rdy,
    input logic rv, input logic [63:0] rd, input logic req, input logic [31:0] addr,
    input logic fl, input logic va, input logic [31:0] ia, input logic [31:0] aa,
    input logic vb, input logic [31:0] ib, input logic [31:0] ab);
    vec_t v;
    v = '{red: red, rpc: rpc, st: st, rdy: rdy, rv: rv, rd: rd, req: req, addr: addr,
          fl: fl, va: va, ia: ia, aa: aa, vb: vb, ib: ib, ab: ab};
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    redirect    = v.red;
    redirect_pc = v.rpc;
    stall       = v.st;
    mem_ready   = v.rdy;
    mem_rvalid  = v.rv;
    mem_rdata   = v.rd;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic bad;
    checks++;
    bad = (mem_req !== v.req) || (mem_addr !== v.addr) || (flush !== v.fl) ||
          (instructionA_valid !== v.va) || (instructionB_valid !== v.vb) ||
          (v.va && ((instructionA !== v.ia) || (addressA !== v.aa))) ||
          (v.vb && ((instructionB !== v.ib) || (addressB !== v.ab)));
    if (bad) begin
      errors++;
      $display("[TB] FAIL %s: got req=%0b addr=%h flush=%0b A=%0b %h@%h B=%0b %h@%h; want req=%0b addr=%h flush=%0b A=%0b %h@%h B=%0b %h@%h",
               name, mem_req, mem_addr, flush, instructionA_valid, instructionA, addressA,
               instructionB_valid, instructionB, addressB, v.req, v.addr, v.fl, v.va, v.ia,
               v.aa, v.vb, v.ib, v.ab);
    end
  endtask

  initial begin
    vec_t  v;
    logic [31:0] blk;
    logic [31:0] pat;

    // Fields: redirect, redirect_pc, stall, ready, rvalid, rdata |
    //         req, addr, flush, vA, iA, aA, vB, iB, aB
    vecs[0]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0,                        1'b1, 32'h0,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[1]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, {32'hB, 32'hA},               1'b1, 32'h8,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[2]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, {32'hD, 32'hC},               1'b1, 32'h10,  1'b0, 1'b1, 32'hA, 32'h0, 1'b1, 32'hB, 32'h4);
    vecs[3]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0,                        1'b1, 32'h18,  1'b0, 1'b1, 32'hC, 32'h8, 1'b1, 32'hD, 32'hC);
    vecs[4]  = mk(1'b1, 32'h107, 1'b0, 1'b1, 1'b0, 64'h0,                      1'b0, 32'h20,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[5]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, JUNK,                         1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[6]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, JUNK,                         1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[7]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0,                        1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[8]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, {32'h1111_0104, 32'h1111_0100}, 1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[9]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0,                        1'b1, 32'h110, 1'b0, 1'b1, 32'h1111_0104, 32'h104, 1'b0, 32'h0, 32'h0);
    vecs[10] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, {32'h2222_010C, 32'h2222_0108}, 1'b1, 32'h110, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[11] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0,                        1'b1, 32'h110, 1'b0, 1'b1, 32'h2222_0108, 32'h108, 1'b1, 32'h2222_010C, 32'h10C);
    vecs[12] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0,                        1'b1, 32'h110, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[13] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0,                        1'b1, 32'h118, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[14] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0,                        1'b0, 32'h120, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[15] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, {32'h3333_0114, 32'h3333_0110}, 1'b0, 32'h120, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[16] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, {32'h4444_011C, 32'h4444_0118}, 1'b0, 32'h120, 1'b0, 1'b1, 32'h3333_0110, 32'h110, 1'b1, 32'h3333_0114, 32'h114);
    vecs[17] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 64'h0,                        1'b0, 32'h120, 1'b0, 1'b1, 32'h4444_0118, 32'h118, 1'b1, 32'h4444_011C, 32'h11C);
    vecs[18] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 64'h0,                        1'b0, 32'h120, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[19] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 64'h0,                        1'b0, 32'h120, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[20] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0,                        1'b1, 32'h120, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[21] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0,                        1'b1, 32'h128, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[22] = mk(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, JUNK,                       1'b0, 32'h130, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[23] = mk(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 64'h0,                      1'b0, 32'h200, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[24] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, JUNK,                         1'b0, 32'h300, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[25] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0,                        1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[26] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, {32'h5555_0304, 32'h5555_0300}, 1'b1, 32'h308, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[27] = mk(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 64'h0,                1'b0, 32'h308, 1'b0, 1'b1, 32'h5555_0300, 32'h300, 1'b1, 32'h5555_0304, 32'h304);
    vecs[28] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0,                        1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[29] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, {32'h6666_FFFC, 32'h6666_FFF8}, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[30] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, {32'h7777_0004, 32'h7777_0000}, 1'b1, 32'h8, 1'b0, 1'b1, 32'h6666_FFF8, 32'hFFFF_FFF8, 1'b1, 32'h6666_FFFC, 32'hFFFF_FFFC);
    vecs[31] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0,                        1'b1, 32'h8, 1'b0, 1'b1, 32'h7777_0000, 32'h0, 1'b1, 32'h7777_0004, 32'h4);

    // Reset held with memory ready: nothing may be requested.
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("reset_state",
                mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0,
                   1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0));

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-operation while slots are valid.
    @(negedge clk);
    applyStimulus(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0,
                     1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset",
                mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0,
                   1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0));

    // Single-cycle memory streaming: one block per cycle from RESET_PC.
    pat = 32'hA5A5_0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) rst = 1'b1;
      blk = 32'(8 * (k - 1));
      mem_ready  = 1'b1;
      mem_rvalid = (k >= 1);
      mem_rdata  = (k >= 1) ? {(blk + 32'd4) ^ pat, blk ^ pat} : 64'h0;
      blk = 32'(8 * (k - 2));
      if (k >= 2) begin
        v = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 64'h0, 1'b1, 32'(8 * k), 1'b0,
               1'b1, blk ^ pat, blk, 1'b1, (blk + 32'd4) ^ pat, blk + 32'd4);
      end else begin
        v = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 32'(8 * k), 1'b0,
               1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      end
      #1;
      checkOutput($sformatf("stream%0d", k), v);
    end

    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_ready  = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got no end of test, want finish before 100000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Front-end controller that sequences instruction fetch for the dual-issue pipeline. Owns the fetch PC, issues 64-bit aligned fetch requests to instruction memory, and hands up to two instructions per cycle (slot A older than slot B) to the InstructionBuffer. Honours the buffer's `stall`, and on a branch or exception `redirect` it flushes the buffer, discards in-flight responses and restarts at the new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered memory requests, range 1..3.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `redirect`  in  1  one-cycle pulse from branch/exception unit.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] ignored and treated as 0.
- `stall`  in  1  InstructionBuffer is near full; no new requests may be issued.
- `mem_req`  out  1  fetch request.
- `mem_addr`  out  32  request address; bits [2:0] always 0.
- `mem_ready`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  response valid; responses return in request order.
- `mem_rdata`  in  64  [31:0] is the word at `mem_addr`, [63:32] is the word at `mem_addr`+4.
- `instructionA`, `instructionB`  out  32  instructions to the buffer.
- `addressA`, `addressB`  out  32  PCs of those instructions.
- `instructionA_valid`, `instructionB_valid`  out  1  slot valid; B is never valid without A.
- `flush`  out  1  one-cycle buffer flush.

## Operation
- States: RUN and DRAIN. Reset enters RUN.
- `mem_req` = (state RUN) & !`stall` & !`redirect` & (outstanding < MAX_OUTSTANDING). It is combinational. Withdrawing an unaccepted request is legal, because memory samples only when `mem_req` & `mem_ready`.
- `mem_addr` = {pc[31:3], 3'b000}.
- On accept: outstanding +1. pc <= {pc[31:3],3'b000} + 8. A per-request FIFO of depth MAX_OUTSTANDING records pc[2] and the block address.
- On a kept response (discard = 0):
  - If the recorded pc[2] = 0: A = rdata[31:0] at block address, B = rdata[63:32] at block address + 4, both valid.
  - If the recorded pc[2] = 1: A = rdata[63:32] at block address + 4, B invalid.
- Every response decrements outstanding and pops the FIFO.
- On `redirect` (any state):
  - pc <= redirect_pc & ~3.
  - discard <= outstanding − (`mem_rvalid` ? 1 : 0). A response arriving in the redirect cycle is dropped.
  - `flush` <= 1 on the next cycle.
  - State <= DRAIN if the new discard is nonzero, else RUN.
- In DRAIN, each response decrements discard and produces no output. At discard = 0, return to RUN.
- A new redirect during DRAIN recomputes discard by the same rule.
- `stall` blocks only new requests. Responses already in flight are still delivered, so the buffer must keep 2·MAX_OUTSTANDING free entries when it deasserts `stall`.
- Arithmetic: pc wraps modulo 2^32; block 32'hFFFF_FFF8 is followed by 32'h0.

## Timing
- Reset values: pc = RESET_PC, state RUN, outstanding = 0, discard = 0, all valids 0, `flush` 0, instruction and address outputs 0. `mem_req` is 0 during reset.
- The first `mem_req` is asserted in the first cycle after `rst` rises.
- Response to buffer: registered. Output valids assert on the cycle after `mem_rvalid` and last exactly one cycle.
- `redirect` to `flush`: 1 cycle. In the `flush` cycle, both valids are forced 0.
- The first request to redirect_pc is issued in the cycle after `redirect`, if outstanding permits.
- With single-cycle memory, throughput is one block per cycle when `stall` = 0.
- Reset asserted mid-operation clears all state asynchronously; any later memory responses are the memory's responsibility and are not tracked.

## Structure
- Shared `fetch_pkg`:
  - `fetch_state_t` enum {RUN, DRAIN}.
  - `FETCH_BLOCK_BYTES` = 8.
  - `fetch_slot_t` struct {instr, addr, valid}.
- One sub-module, `fetch_tag_fifo`: depth MAX_OUTSTANDING, entries {block_addr, odd}, push on accept, pop on response.
- Counters, FSM and output registers stay in `fetch_sequencer`.

## Test plan
- Reset release, memory ready = 1, 1-cycle latency, rdata = {32'hB, 32'hA} → mem_addr 0x0, 0x8, 0x10 on consecutive cycles; outputs A = 0xA @0x0, B = 0xB @0x4, both valid.
- `redirect_pc` = 0x104 with 2 outstanding → `flush` next cycle; 2 responses dropped; next output A = rdata[63:32] @0x104, B invalid; following block 0x108.
- Hold `stall` = 1 for 5 cycles → no `mem_req`; pending responses still output; resumes at the correct next block when released.
- `mem_ready` = 0 for 3 cycles → mem_addr held; pc does not advance; outstanding never exceeds 2.
- Redirect coinciding with `mem_rvalid`, then a second redirect during DRAIN → no stale instruction output; discard reaches 0; fetch restarts at the last redirect_pc.
- Start at 0xFFFF_FFF8 → next mem_addr 0x0000_0000.
